// File: rtl/p2s_tx_scheduler_if.sv
// Requester-side handshake bundle for the serial TX scheduler.
// Requesters drive valid/data; the scheduler returns a one-hot accept strobe.
interface p2s_tx_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int SERIAL_LEN = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*SERIAL_LEN-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/p2s_tx_scheduler.sv
// Round-robin word scheduler feeding the parallel-to-serial shifter.
// Emits per-bit framing aligned to the shifter's serial output.
module p2s_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int SERIAL_LEN = 8,
  parameter int GAP_CYCLES = 1,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_enable,
  p2s_tx_scheduler_if.slave     req,
  output logic                  p2s_load,
  output logic [SERIAL_LEN-1:0] p2s_parallel_in,
  input  logic                  p2s_serial_in,
  output logic                  tx_bit,
  output logic                  tx_valid,
  output logic                  tx_sof,
  output logic                  tx_eof,
  output logic [ID_W-1:0]       tx_id,
  output logic                  busy
);

  localparam int CW = $clog2(SERIAL_LEN) + 1;
  localparam int GW =
    (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GLAST =
    (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   bit_cnt, bit_cnt_d;
  logic [GW-1:0]   gap_cnt, gap_cnt_d;
  logic [ID_W-1:0] rr_ptr, rr_ptr_d;
  logic [ID_W-1:0] tx_id_d;
  logic [ID_W-1:0] gnt;
  logic            gnt_found;
  int              idx;

  // first valid requester at or above rr_ptr, wrapping
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!gnt_found && req.req_valid[idx]) begin
        gnt       = ID_W'(idx);
        gnt_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d         = state;
    bit_cnt_d       = bit_cnt;
    gap_cnt_d       = gap_cnt;
    rr_ptr_d        = rr_ptr;
    tx_id_d         = tx_id;
    p2s_load        = 1'b0;
    p2s_parallel_in = '0;
    req.req_ready   = '0;
    tx_valid        = 1'b0;
    tx_sof          = 1'b0;
    tx_eof          = 1'b0;
    unique case (state)
      IDLE: begin
        // no accept strobe while reset is asserted
        if (cfg_enable && gnt_found && !rst) begin
          p2s_load        = 1'b1;
          p2s_parallel_in = req.req_data[
            int'(gnt)*SERIAL_LEN +: SERIAL_LEN];
          req.req_ready[gnt] = 1'b1;
          tx_id_d   = gnt;
          rr_ptr_d  = (int'(gnt) == NUM_REQ - 1)
                    ? '0 : gnt + 1'b1;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        tx_valid  = 1'b1;
        tx_sof    = (bit_cnt == '0);
        tx_eof    = (bit_cnt == CW'(SERIAL_LEN - 1));
        bit_cnt_d = bit_cnt + 1'b1;
        if (tx_eof) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GLAST)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      rr_ptr  <= '0;
      tx_id   <= '0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      gap_cnt <= gap_cnt_d;
      rr_ptr  <= rr_ptr_d;
      tx_id   <= tx_id_d;
    end
  end

  assign tx_bit = p2s_serial_in;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_p2s_tx_scheduler.sv
// Bench for p2s_tx_scheduler: shifter model, frame scoreboard,
// plus a GAP_CYCLES=0 instance for back-to-back timing.
module tb_p2s_tx_scheduler;

  localparam int NR = 4;
  localparam int SL = 8;

  typedef struct packed {
    logic [1:0]    id;
    logic [SL-1:0] d;
  } frm_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic enz = 1'b0;

  always #5 clk = ~clk;

  p2s_tx_scheduler_if #(.NUM_REQ(NR), .SERIAL_LEN(SL)) ifc ();
  p2s_tx_scheduler_if #(.NUM_REQ(NR), .SERIAL_LEN(SL)) ifz ();

  logic [NR-1:0] vld    = '0;
  logic [NR-1:0] reload = '0;
  logic [NR-1:0] vldz   = '0;
  logic [SL-1:0] dat [NR];
  logic [SL-1:0] datz;

  assign ifc.req_valid = vld;
  for (genvar i = 0; i < NR; i++) begin : g_pack
    assign ifc.req_data[i*SL +: SL] = dat[i];
  end
  assign ifz.req_valid = vldz;
  assign ifz.req_data  = {{((NR-1)*SL){1'b0}}, datz};

  logic          load, sin, tbit, val, sof, eof, busy;
  logic [SL-1:0] pin;
  logic [1:0]    id;
  logic          loadz, sinz, tbitz, valz, sofz, eofz, busyz;
  logic [SL-1:0] pinz;
  logic [1:0]    idz;

  p2s_tx_scheduler #(
    .NUM_REQ(NR), .SERIAL_LEN(SL), .GAP_CYCLES(1)
  ) dut (
    .clk(clk), .rst(rst), .cfg_enable(en), .req(ifc),
    .p2s_load(load), .p2s_parallel_in(pin),
    .p2s_serial_in(sin), .tx_bit(tbit), .tx_valid(val),
    .tx_sof(sof), .tx_eof(eof), .tx_id(id), .busy(busy)
  );

  p2s_tx_scheduler #(
    .NUM_REQ(NR), .SERIAL_LEN(SL), .GAP_CYCLES(0)
  ) dut_z (
    .clk(clk), .rst(rst), .cfg_enable(enz), .req(ifz),
    .p2s_load(loadz), .p2s_parallel_in(pinz),
    .p2s_serial_in(sinz), .tx_bit(tbitz), .tx_valid(valz),
    .tx_sof(sofz), .tx_eof(eofz), .tx_id(idz), .busy(busyz)
  );

  // shifter model: LSB first, bit 0 appears the cycle after load
  logic [SL-1:0] sr  = '0;
  logic [SL-1:0] srz = '0;
  always @(posedge clk) begin
    if (rst)       sr <= '0;
    else if (load) sr <= pin;
    else           sr <= sr >> 1;
    if (rst)        srz <= '0;
    else if (loadz) srz <= pinz;
    else            srz <= srz >> 1;
  end
  assign sin  = sr[0];
  assign sinz = srz[0];

  int checks = 0;
  int errs   = 0;
  int cyc_n  = 0;

  logic [NR-1:0] s_rdy, s_rdyz;
  logic          s_load, s_bit, s_val, s_sof, s_eof, s_busy;
  logic [SL-1:0] s_pin;
  logic [1:0]    s_id;
  logic          s_loadz, s_valz, s_eofz;

  frm_t          exp_q [$];
  logic [SL-1:0] fbits = '0;
  int            fk    = 0;
  int            zg [$];
  int            zbub  = 0;
  int            zeof  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [1:0] i,
                      input logic [SL-1:0] d);
    exp_q.push_back(frm_t'{id: i, d: d});
  endtask

  task automatic cyc();
    frm_t e;
    @(negedge clk);
    cyc_n++;
    s_rdy   = ifc.req_ready;
    s_load  = load;
    s_pin   = pin;
    s_bit   = tbit;
    s_val   = val;
    s_sof   = sof;
    s_eof   = eof;
    s_id    = id;
    s_busy  = busy;
    s_rdyz  = ifz.req_ready;
    s_loadz = loadz;
    s_valz  = valz;
    s_eofz  = eofz;
    if (!s_load) chk("pin_idle", 32'(s_pin), 0);
    if (s_val) begin
      if (s_sof) fk = 0;
      fbits = {s_bit, fbits[SL-1:1]};
      fk++;
      if (s_eof) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("frm_len", fk, SL);
          chk("frm_data", 32'(fbits), 32'(e.d));
          chk("frm_id", 32'(s_id), 32'(e.id));
        end
      end
    end
    if (s_loadz) zg.push_back(cyc_n);
    if (zg.size() >= 1 && zg.size() < 4 && !s_loadz && !s_valz)
      zbub++;
    if (s_eofz) zeof++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (s_rdy[i]) begin
        if (reload[i]) dat[i] = dat[i] + 8'h11;
        else           vld[i] = 1'b0;
      end
    end
    if (s_rdyz[0]) datz = datz + 8'h01;
  endtask

  task automatic wait_grant(input string tag,
                            output logic [NR-1:0] g);
    g = '0;
    for (int n = 0; n < 30; n++) begin
      cyc();
      if (|s_rdy) begin
        g = s_rdy;
        break;
      end
    end
    if (g == '0) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] g;
    logic [SL-1:0] a5;
    int gc [5];
    int n_eof;
    int n_gnt;
    for (int i = 0; i < NR; i++) dat[i] = '0;
    datz = 8'h40;
    a5   = 8'hA5;

    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_val", 32'(s_val), 0);
    chk("rst_load", 32'(s_load), 0);
    chk("rst_rdy", 32'(s_rdy), 0);
    chk("rst_id", 32'(s_id), 0);
    chk("rst_eof", 32'(s_eof), 0);
    rst = 1'b0;
    en  = 1'b1;

    // single word
    dat[0] = 8'hA5;
    push(2'd0, 8'hA5);
    vld = 4'b0001;
    cyc();
    chk("t1_rdy", 32'(s_rdy), 32'h1);
    chk("t1_load", 32'(s_load), 1);
    chk("t1_pin", 32'(s_pin), 32'hA5);
    for (int k = 0; k < SL; k++) begin
      cyc();
      chk("t1_val", 32'(s_val), 1);
      chk("t1_sof", 32'(s_sof), 32'(k == 0));
      chk("t1_eof", 32'(s_eof), 32'(k == SL - 1));
      chk("t1_bit", 32'(s_bit), 32'(a5[k]));
      chk("t1_rdy0", 32'(s_rdy), 0);
      chk("t1_load0", 32'(s_load), 0);
    end
    cyc();
    chk("t1_gap_val", 32'(s_val), 0);
    chk("t1_gap_busy", 32'(s_busy), 1);
    cyc();
    chk("t1_idle", 32'(s_busy), 0);

    // round-robin with all requesters valid
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    dat[0] = 8'h10;
    dat[1] = 8'h20;
    dat[2] = 8'h30;
    dat[3] = 8'h40;
    push(2'd0, 8'h10);
    push(2'd1, 8'h20);
    push(2'd2, 8'h30);
    push(2'd3, 8'h40);
    push(2'd0, 8'h21);
    reload = 4'hF;
    vld    = 4'hF;
    for (int n = 0; n < 5; n++) begin
      wait_grant("t2", g);
      gc[n] = cyc_n;
      chk("t2_order", 32'(g), 32'(1) << (n % 4));
    end
    vld    = '0;
    reload = '0;
    for (int n = 1; n < 5; n++)
      chk("t2_period", gc[n] - gc[n-1], 10);
    repeat (10) cyc();

    // pointer ends at 3, then wrap to 0 and skip to 2
    dat[2] = 8'h5A;
    push(2'd2, 8'h5A);
    vld = 4'b0100;
    wait_grant("t3a", g);
    chk("t3_pre", 32'(g), 32'h4);
    repeat (9) cyc();
    dat[0] = 8'hC3;
    dat[2] = 8'h3C;
    push(2'd0, 8'hC3);
    push(2'd2, 8'h3C);
    vld = 4'b0101;
    wait_grant("t3b", g);
    chk("t3_wrap", 32'(g), 32'h1);
    wait_grant("t3c", g);
    chk("t3_skip", 32'(g), 32'h4);
    repeat (9) cyc();

    // disable mid-frame: frame completes, no new grant
    dat[1] = 8'hE7;
    push(2'd1, 8'hE7);
    vld = 4'b0010;
    wait_grant("t4", g);
    chk("t4_gnt", 32'(g), 32'h2);
    cyc();
    cyc();
    en     = 1'b0;
    dat[3] = 8'h99;
    vld    = 4'b1000;
    n_eof  = 0;
    n_gnt  = 0;
    repeat (20) begin
      cyc();
      if (s_eof) n_eof++;
      if (|s_rdy) n_gnt++;
    end
    chk("t4_eof", n_eof, 1);
    chk("t4_nogrant", n_gnt, 0);
    chk("t4_idle", 32'(s_busy), 0);
    push(2'd3, 8'h99);
    en = 1'b1;
    cyc();
    chk("t4_regrant", 32'(s_rdy), 32'h8);
    repeat (9) cyc();

    // reset at bit 4 aborts the frame and clears the pointer
    dat[2] = 8'hB4;
    vld = 4'b0100;
    wait_grant("t5", g);
    chk("t5_gnt", 32'(g), 32'h4);
    repeat (4) cyc();
    rst = 1'b1;
    cyc();
    chk("t5_bit4_val", 32'(s_val), 1);
    chk("t5_bit4_bit", 32'(s_bit), 1);
    cyc();
    chk("t5_val", 32'(s_val), 0);
    chk("t5_busy", 32'(s_busy), 0);
    chk("t5_eof", 32'(s_eof), 0);
    chk("t5_id", 32'(s_id), 0);
    rst = 1'b0;
    vld = '0;
    dat[0] = 8'h11;
    dat[3] = 8'h33;
    push(2'd0, 8'h11);
    push(2'd3, 8'h33);
    vld = 4'b1001;
    wait_grant("t5b", g);
    chk("t5_prio", 32'(g), 32'h1);
    wait_grant("t5c", g);
    chk("t5_next", 32'(g), 32'h8);
    repeat (9) cyc();

    // zero-gap build: back-to-back frames
    enz  = 1'b1;
    vldz = 4'b0001;
    for (int n = 0; n < 60 && zg.size() < 4; n++) cyc();
    vldz = '0;
    enz  = 1'b0;
    chk("t6_grants", 32'(zg.size() >= 4), 1);
    if (zg.size() >= 4) begin
      for (int n = 1; n < 4; n++)
        chk("t6_period", zg[n] - zg[n-1], 9);
    end
    repeat (10) cyc();
    chk("t6_bubble", zbub, 0);
    chk("t6_eof", zeof, 4);

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
